fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch queue, sitting between instruction memory and the decode (ID) stage of the pipelined datapath. It generates fetch addresses and holds one outstanding request on a req/ack memory handshake. It buffers up to DEPTH fetched instructions with their PC+1, and presents them to decode under a valid/ready handshake. A redirect (jump/branch/JR resolution) flushes the queue and restarts fetch, and any response already in flight is discarded.

---
 rtl/fetch_queue_if.sv | 37 +++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// ============================================================================
// fetch_queue_if : memory request and decode handshake bundle for fetch_queue
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_queue_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  i_address;
   logic               i_req;
   logic               i_ack;
   logic [DATA_W-1:0]  i_data;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               deq_ready;
   logic               deq_valid;
   logic [DATA_W-1:0]  deq_inst;
   logic [ADDR_W-1:0]  deq_pc_plus1;
   logic [c_CNT_W-1:0] count;

   modport master (
      output i_address, i_req, deq_valid, deq_inst, deq_pc_plus1, count,
      input  i_ack, i_data, redirect, redirect_pc, deq_ready
   );

   modport slave (
      input  i_address, i_req, deq_valid, deq_inst, deq_pc_plus1, count,
      output i_ack, i_data, redirect, redirect_pc, deq_ready
   );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : instruction fetch front end with prefetch queue and redirect
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int              DATA_W   = 16,
   parameter int              ADDR_W   = 16,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire logic       Clk,
   input  wire logic       Reset,
   fetch_queue_if.master   bus
);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_drop_addr;
   logic [DATA_W-1:0]   r_inst [DEPTH];
   logic [ADDR_W-1:0]   r_pcp1 [DEPTH];
   logic [c_PTR_W-1:0]  r_head;
   logic [c_PTR_W-1:0]  r_tail;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_valid;
   logic                w_deq;
   logic                w_enq;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [c_CNT_W-1:0]  w_cnt_after_enq;

   assign w_valid         = (r_count != '0);
   assign w_deq           = w_valid && bus.deq_ready;
   assign w_enq           = (r_state == S_REQ) && bus.i_ack && !bus.redirect;
   assign w_pc_inc        = r_pc + 1'b1;
   assign w_cnt_after_enq = r_count + c_CNT_W'(1) - c_CNT_W'(w_deq);

   assign bus.i_req        = (r_state != S_IDLE);
   assign bus.i_address    = (r_state == S_DROP) ? r_drop_addr : r_pc;
   assign bus.deq_valid    = w_valid;
   assign bus.deq_inst     = w_valid ? r_inst[r_head] : '0;
   assign bus.deq_pc_plus1 = w_valid ? r_pcp1[r_head] : '0;
   assign bus.count        = r_count;

   // Storage carries no reset; occupancy is tracked solely by r_count.
   always_ff @(posedge Clk) begin
      if (w_enq) begin
         r_inst[r_tail] <= bus.i_data;
         r_pcp1[r_tail] <= w_pc_inc;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_drop_addr <= RESET_PC;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
      end else begin
         if (bus.redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_deq) r_head <= r_head + 1'b1;
            if (w_enq) r_tail <= r_tail + 1'b1;
            r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
         end

         case (r_state)
            S_IDLE: begin
               if (bus.redirect) begin
                  r_pc    <= bus.redirect_pc;
                  r_state <= S_REQ;
               end else if ((r_count < c_FULL) || w_deq) begin
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.i_ack) begin
                  if (bus.redirect) begin
                     r_pc <= bus.redirect_pc;
                  end else begin
                     r_pc <= w_pc_inc;
                     if (w_cnt_after_enq >= c_FULL) r_state <= S_IDLE;
                  end
               end else if (bus.redirect) begin
                  // The old request cannot be retracted; remember it to finish it.
                  r_drop_addr <= r_pc;
                  r_pc        <= bus.redirect_pc;
                  r_state     <= S_DROP;
               end
            end
            S_DROP: begin
               if (bus.redirect) r_pc <= bus.redirect_pc;
               if (bus.i_ack)    r_state <= S_REQ;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : directed and random checks of fetch_queue against a queue model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;
   localparam int          DW     = 16;
   localparam int          AW     = 16;
   localparam int          DEPTH  = 4;
   localparam logic [15:0] RST_PC = 16'hFFFE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] inst;
      logic [15:0] pcp1;
   } ent_t;

   ent_t        m_q[$];
   logic [15:0] m_pc;
   logic [15:0] m_stale_addr;
   bit          m_busy;
   bit          m_stale;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc         = RST_PC;
      m_stale_addr = RST_PC;
      m_busy       = 1'b0;
      m_stale      = 1'b0;
   endtask

   // Memory returns data equal to the address, so an accepted fetch stores {pc, pc+1}.
   task automatic model_edge(input bit ack, input bit redir, input logic [15:0] rpc, input bit ready);
      int          pre;
      bit          deq;
      logic [15:0] nxt;
      pre = m_q.size();
      deq = (pre > 0) && ready;
      if (redir) begin
         if (m_busy && !m_stale && !ack) begin
            m_stale      = 1'b1;
            m_stale_addr = m_pc;
         end else if (m_stale && ack) begin
            m_stale = 1'b0;
         end
         m_busy = 1'b1;
         m_pc   = rpc;
         m_q.delete();
      end else if (!m_busy) begin
         if (deq) void'(m_q.pop_front());
         m_busy = (pre < DEPTH) || deq;
      end else if (m_stale) begin
         if (deq) void'(m_q.pop_front());
         if (ack) m_stale = 1'b0;
      end else begin
         if (ack) begin
            nxt = m_pc + 16'd1;
            m_q.push_back('{inst: m_pc, pcp1: nxt});
            m_pc = nxt;
         end
         if (deq) void'(m_q.pop_front());
         if (ack) m_busy = (m_q.size() < DEPTH);
      end
   endtask

   task automatic check_all();
      bit v;
      v = (m_q.size() > 0);
      chk("i_req",        32'(bus.i_req),        32'(m_busy));
      chk("i_address",    32'(bus.i_address),    32'(m_stale ? m_stale_addr : m_pc));
      chk("deq_valid",    32'(bus.deq_valid),    32'(v));
      chk("deq_inst",     32'(bus.deq_inst),     v ? 32'(m_q[0].inst) : 32'd0);
      chk("deq_pc_plus1", 32'(bus.deq_pc_plus1), v ? 32'(m_q[0].pcp1) : 32'd0);
      chk("count",        32'(bus.count),        32'(m_q.size()));
   endtask

   task automatic cycle(input bit ack, input bit redir, input logic [15:0] rpc, input bit ready);
      bus.i_ack       = ack;
      bus.i_data      = bus.i_address;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      bus.deq_ready   = ready;
      @(posedge clk);
      model_edge(ack, redir, rpc, ready);
      #1 check_all();
   endtask

   initial begin
      int thr;
      bit ack, redir, ready;
      logic [15:0] rpc;

      bus.i_ack       = 1'b0;
      bus.i_data      = '0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.deq_ready   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", 32'(bus.i_address), 32'(RST_PC));
      check_all();
      rst = 1'b0;

      // Zero-wait streaming through the address wrap at 0xFFFF.
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      repeat (12) cycle(1'b1, 1'b0, 16'h0, 1'b1);

      // Decode stall fills the queue, then drains.
      repeat (8) cycle(1'b1, 1'b0, 16'h0, 1'b0);
      chk("stall_count", 32'(bus.count), 32'd4);
      chk("stall_req",   32'(bus.i_req), 32'd0);
      repeat (6) cycle(1'b1, 1'b0, 16'h0, 1'b1);

      // Redirect during a memory wait leaves a request to complete.
      cycle(1'b0, 1'b1, 16'h0040, 1'b1);
      chk("redir_empty", 32'(bus.count), 32'd0);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      chk("after_drop_addr", 32'(bus.i_address), 32'h0040);
      repeat (4) cycle(1'b1, 1'b0, 16'h0, 1'b1);

      // Redirect coinciding with ack and dequeue at count 2.
      repeat (4) cycle(1'b0, 1'b0, 16'h0, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, 16'h0, 1'b0);
      chk("pre_count2", 32'(bus.count), 32'd2);
      cycle(1'b1, 1'b1, 16'h1234, 1'b1);
      chk("co_count", 32'(bus.count),     32'd0);
      chk("co_valid", 32'(bus.deq_valid), 32'd0);
      chk("co_addr",  32'(bus.i_address), 32'h1234);
      chk("co_req",   32'(bus.i_req),     32'd1);

      // Asynchronous reset while completing a dropped request.
      cycle(1'b0, 1'b1, 16'h2000, 1'b1);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("drop_addr", 32'(bus.i_address), 32'h1234);
      #3 rst = 1'b1;
      #1;
      chk("arst_req",   32'(bus.i_req),     32'd0);
      chk("arst_valid", 32'(bus.deq_valid), 32'd0);
      model_reset();
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      chk("restart_addr", 32'(bus.i_address), 32'(RST_PC));

      thr = 60;
      for (int i = 0; i < 1500; i++) begin
         if (i % 200 == 0) thr = $urandom_range(20, 100);
         ack   = ($urandom_range(0, 99) < thr);
         redir = ($urandom_range(0, 99) < 6);
         rpc   = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                             : 16'($urandom);
         ready = ($urandom_range(0, 99) < 65);
         cycle(ack, redir, rpc, ready);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
